// File: rtl/ltssm_timer_bank_if.sv
// ltssm_timer_bank_if
//   Bundle between an LTSSM controller (master) and the shared timer bank (slave).
//   Master drives: Gen, Start, Stop, Enable, TimerIntervalCode, ReadSel.
//   Slave drives : Running, TimeOut, TimeOutPulse (registered) and ReadCount
//                  (combinational readback of the channel chosen by ReadSel).
interface ltssm_timer_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [2:0]            Gen;
  logic [CHANNELS-1:0]   Start;
  logic [CHANNELS-1:0]   Stop;
  logic [CHANNELS-1:0]   Enable;
  logic [3*CHANNELS-1:0] TimerIntervalCode;
  logic [CHANNELS-1:0]   Running;
  logic [CHANNELS-1:0]   TimeOut;
  logic [CHANNELS-1:0]   TimeOutPulse;
  logic [SELW-1:0]       ReadSel;
  logic [WIDTH-1:0]      ReadCount;

  modport master (
    output Gen, Start, Stop, Enable, TimerIntervalCode, ReadSel,
    input  Running, TimeOut, TimeOutPulse, ReadCount
  );

  modport slave (
    input  Gen, Start, Stop, Enable, TimerIntervalCode, ReadSel,
    output Running, TimeOut, TimeOutPulse, ReadCount
  );
endinterface

// File: rtl/ltssm_timer_bank.sv
// ltssm_timer_bank
//   Bank of CHANNELS independent one-shot timeout timers shared by the LTSSM
//   and its substates. Each channel latches its interval (ms code scaled by
//   rate and PIPE width) when started, so rate changes never disturb a timer
//   already in flight.
// Ports:
//   Pclk  - clock, all state changes on the rising edge
//   Reset - asynchronous active-low reset
//   bus   - slave side of ltssm_timer_bank_if (per-channel start/stop/enable,
//           interval codes, rate, expiry level/pulse, running status, readback)
module ltssm_timer_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 32,
  parameter int BASE_1MS       = 62500,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int SELW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic               Pclk,
  input logic               Reset,
  ltssm_timer_bank_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Interval in Pclk cycles: ms * BASE_1MS * rate factor * pipe factor,
  // computed in 64 bits and clamped to all-ones when it does not fit WIDTH.
  function automatic logic [WIDTH-1:0] calc_interval(input logic [2:0] code,
                                                      input logic [2:0] gen);
    logic [6:0]  ms;
    logic [2:0]  g;
    logic [2:0]  p;
    int          pw;
    logic [63:0] prod;
    logic [63:0] lim;
    case (code)
      3'b000:  ms = 7'd0;
      3'b001:  ms = 7'd12;
      3'b010:  ms = 7'd24;
      3'b011:  ms = 7'd48;
      3'b100:  ms = 7'd2;
      3'b101:  ms = 7'd8;
      3'b110:  ms = 7'd1;
      3'b111:  ms = 7'd100;
      default: ms = 7'd0;
    endcase
    // Unknown rate encodings are treated as Gen1.
    case (gen)
      3'b010:  begin g = 3'd2; pw = GEN2_PIPEWIDTH; end
      3'b011:  begin g = 3'd4; pw = GEN3_PIPEWIDTH; end
      default: begin g = 3'd1; pw = GEN1_PIPEWIDTH; end
    endcase
    if (pw == 32'sd32) begin
      p = 3'd1;
    end else if (pw == 32'sd16) begin
      p = 3'd2;
    end else begin
      p = 3'd4;
    end
    prod = 64'(ms) * 64'(BASE_1MS) * 64'(g) * 64'(p);
    lim  = (64'd1 << WIDTH) - 64'd1;
    if (prod > lim) begin
      return {WIDTH{1'b1}};
    end else begin
      return prod[WIDTH-1:0];
    end
  endfunction

  state_e              state_q    [CHANNELS];
  state_e              state_d    [CHANNELS];
  logic [WIDTH-1:0]    count_q    [CHANNELS];
  logic [WIDTH-1:0]    count_d    [CHANNELS];
  logic [WIDTH-1:0]    interval_q [CHANNELS];
  logic [WIDTH-1:0]    interval_d [CHANNELS];
  logic [WIDTH-1:0]    start_n_s  [CHANNELS];
  logic [CHANNELS-1:0] running_q, running_d;
  logic [CHANNELS-1:0] timeout_q, timeout_d;
  logic [CHANNELS-1:0] pulse_q,   pulse_d;
  logic [SELW-1:0]     sel_s;
  logic [WIDTH-1:0]    read_s;

  // Interval each channel would latch if started on this edge.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      start_n_s[c] = calc_interval(bus.TimerIntervalCode[3*c +: 3], bus.Gen);
    end
  end

  // Per-channel next state: Stop beats Start beats Enable.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]    = state_q[c];
      count_d[c]    = count_q[c];
      interval_d[c] = interval_q[c];
      pulse_d[c]    = 1'b0;
      if (bus.Stop[c]) begin
        state_d[c] = ST_IDLE;
        count_d[c] = CNT_ZERO;
      end else if (bus.Start[c]) begin
        interval_d[c] = start_n_s[c];
        count_d[c]    = CNT_ZERO;
        // A zero interval expires on the start edge itself.
        if (start_n_s[c] == CNT_ZERO) begin
          state_d[c] = ST_EXPIRED;
          pulse_d[c] = 1'b1;
        end else begin
          state_d[c] = ST_RUN;
        end
      end else begin
        case (state_q[c])
          ST_RUN, ST_PAUSE: begin
            // PAUSE counts on the same edge Enable returns, like RUN.
            if (bus.Enable[c]) begin
              if ((count_q[c] + CNT_ONE) == interval_q[c]) begin
                state_d[c] = ST_EXPIRED;
                count_d[c] = interval_q[c];
                pulse_d[c] = 1'b1;
              end else begin
                state_d[c] = ST_RUN;
                count_d[c] = count_q[c] + CNT_ONE;
              end
            end else begin
              state_d[c] = ST_PAUSE;
            end
          end
          ST_IDLE:    state_d[c] = ST_IDLE;
          ST_EXPIRED: state_d[c] = ST_EXPIRED;
          default: begin
            state_d[c] = ST_IDLE;
            count_d[c] = CNT_ZERO;
          end
        endcase
      end
      running_d[c] = (state_d[c] == ST_RUN) || (state_d[c] == ST_PAUSE);
      timeout_d[c] = (state_d[c] == ST_EXPIRED);
    end
  end

  // Channel state, counters, latched intervals and registered status outputs.
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]    <= ST_IDLE;
        count_q[c]    <= CNT_ZERO;
        interval_q[c] <= CNT_ZERO;
      end
      running_q <= {CHANNELS{1'b0}};
      timeout_q <= {CHANNELS{1'b0}};
      pulse_q   <= {CHANNELS{1'b0}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]    <= state_d[c];
        count_q[c]    <= count_d[c];
        interval_q[c] <= interval_d[c];
      end
      running_q <= running_d;
      timeout_q <= timeout_d;
      pulse_q   <= pulse_d;
    end
  end

  assign sel_s = bus.ReadSel;

  // Readback mux; selects beyond the last channel read as zero.
  always_comb begin
    if (int'(sel_s) < CHANNELS) begin
      read_s = count_q[sel_s];
    end else begin
      read_s = CNT_ZERO;
    end
  end

  assign bus.ReadCount    = read_s;
  assign bus.Running      = running_q;
  assign bus.TimeOut      = timeout_q;
  assign bus.TimeOutPulse = pulse_q;

endmodule
